// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit field positions, lane indices and
// the golden-epoch FSM state type.
package noc_pkg;

  localparam int FLIT_W   = 32;
  localparam int GOLD_BIT = 0;
  localparam int SEQ_MSB  = 19;
  localparam int SEQ_LSB  = 15;
  localparam int SRC_MSB  = 24;
  localparam int SRC_LSB  = 20;
  localparam int NODE_W   = SRC_MSB - SRC_LSB + 1;
  localparam int LANES    = 4;

  localparam int LANE_N = 0;
  localparam int LANE_E = 1;
  localparam int LANE_S = 2;
  localparam int LANE_W = 3;

  typedef enum logic {IDLE, RUN} epoch_state_t;

  // Number of set bits in a lane mask (0..4).
  function automatic logic [2:0] lane_popcnt(input logic [LANES-1:0] m);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {2'b0, m[i]};
    return n;
  endfunction

endpackage

// File: rtl/golden_epoch_ctrl_if.sv
// Lane bus between the input latches and the arbiter network.
// master drives flits in and watches the stamped result; slave is the stamper.
interface golden_epoch_ctrl_if import noc_pkg::*; ();
  logic [LANES-1:0]             in_valid;
  logic [LANES-1:0][FLIT_W-1:0] in_flit;
  logic [LANES-1:0]             out_valid;
  logic [LANES-1:0][FLIT_W-1:0] out_flit;

  modport master (output in_valid, in_flit, input out_valid, out_flit);
  modport slave  (input in_valid, in_flit, output out_valid, out_flit);
endinterface

// File: rtl/golden_stamp_lane.sv
// Per-lane golden bit rewrite: bit 0 is replaced (never OR'd) by
// valid & running & (source id == current golden node). All other bits pass.
module golden_stamp_lane import noc_pkg::*; (
  input  logic              vld,
  input  logic              run,
  input  logic [NODE_W-1:0] gold_node,
  input  logic [FLIT_W-1:0] flit_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              gold
);
  // Incoming golden bit is deliberately discarded.
  logic unused_gold_in;
  assign unused_gold_in = flit_in[GOLD_BIT];

  // Ids >= NUM_NODES can never equal gold_node, so no range check is needed.
  assign gold     = vld & run & (flit_in[SRC_MSB:SRC_LSB] == gold_node);
  assign flit_out = {flit_in[FLIT_W-1:GOLD_BIT+1], gold};
endmodule

// File: rtl/golden_epoch_ctrl.sv
// Golden-epoch scheduler: epoch counter, round-robin golden node and a
// registered stamping stage for the four router input lanes.
// Optional golden-flit statistics counter under macro GOLDEN_EPOCH_STATS_EN.
module golden_epoch_ctrl import noc_pkg::*; #(
  parameter int EPOCH_LEN = 16,
  parameter int NUM_NODES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  golden_epoch_ctrl_if.slave bus,
  output logic [NODE_W-1:0] gold_node,
`ifdef GOLDEN_EPOCH_STATS_EN
  output logic [15:0]       gold_cnt,
`endif
  output logic              epoch_tick
);
  localparam logic [15:0]       LAST_CNT  = 16'(EPOCH_LEN - 1);
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);

  epoch_state_t                 state;
  logic [15:0]                  cnt;
  logic                         run;
  logic                         expire;
  logic [LANES-1:0][FLIT_W-1:0] stamped;
  logic [LANES-1:0]             gold;

  assign run    = (state == RUN);
  assign expire = run & en & ~stall & (cnt == LAST_CNT);

  // Epoch FSM: counter, golden-node rotation and tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      gold_node  <= '0;
      epoch_tick <= 1'b0;
    end else begin
      epoch_tick <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          // Disable wins over stall and over expiry; gold_node survives.
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!stall) begin
            if (cnt == LAST_CNT) begin
              cnt        <= '0;
              gold_node  <= (gold_node == LAST_NODE) ? '0 : gold_node + 1'b1;
              epoch_tick <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane stampers see the pre-edge gold_node, so a tick edge still uses the old node.
  golden_stamp_lane u_lane [LANES-1:0] (
    .vld      (bus.in_valid),
    .run      (run),
    .gold_node(gold_node),
    .flit_in  (bus.in_flit),
    .flit_out (stamped),
    .gold     (gold)
  );

  // Output register stage; stall freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= '0;
      bus.out_flit  <= '0;
    end else if (!stall) begin
      bus.out_valid <= bus.in_valid;
      bus.out_flit  <= stamped;
    end
  end

`ifdef GOLDEN_EPOCH_STATS_EN
  logic [2:0]  n_gold;
  logic [16:0] cnt_sum;

  assign n_gold  = lane_popcnt(gold);
  assign cnt_sum = {1'b0, gold_cnt} + {14'b0, n_gold};

  // Golden stamps per epoch, saturating; restarts with the tick edge's own stamps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gold_cnt <= '0;
    end else if (!stall) begin
      if (expire) gold_cnt <= {13'b0, n_gold};
      else        gold_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{expire, gold};
`endif

endmodule

// File: doc/golden_epoch_ctrl.md
Name: golden_epoch_ctrl

Overview:
- Per-router golden-flit scheduler for the bufferless 2x2-arbiter router.
- Owns the global golden epoch: counts cycles, rotates the golden source node round-robin, and stamps flit bit 0 (golden) on the four input lanes before they reach the arbiter stage.
- Every router runs an identical instance from the same reset, so the golden node stays network-consistent without signalling.
- Registered stage inserted between the input latches and the arbiter network.

Parameters:
- EPOCH_LEN, 16, cycles per golden epoch; legal range 2..65535.
- NUM_NODES, 16, number of source nodes rotated through; legal range 2..32.
- LANES, 4, number of router input lanes; fixed at 4 (N,E,S,W).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  scheduler enable; low = no flit is golden
- stall  input  1  downstream hold; freezes outputs and epoch counter
- in_valid  input  4  per-lane flit valid
- in_flit  input  128  lane i occupies [32i+31:32i]
- out_valid  output  4  registered lane valid
- out_flit  output  128  registered flits with golden bit rewritten
- gold_node  output  5  current golden source node id
- epoch_tick  output  1  one-cycle pulse when gold_node advances

Behaviour:
- Flit fields: bit 0 golden; [19:15] sequence number (arbiter tie-break); [24:20] source node id.
- Reset (async, rst_n=0):
  - out_valid=0, out_flit=0, gold_node=0, epoch_tick=0, epoch count=0.
  - FSM=IDLE.
  - Mid-operation reset discards all in-flight lanes immediately.
- FSM states:
  - IDLE: count held at 0; gold_node held. IDLE->RUN when en=1, evaluated on the same cycle's edge.
  - RUN: count advances. RUN->IDLE when en=0; this takes priority over stall and over epoch expiry. Count is cleared on entry to IDLE; gold_node is kept.
- Epoch counter, in RUN with stall=0:
  - count<EPOCH_LEN-1: count+1.
  - count==EPOCH_LEN-1: count<=0; gold_node <= (gold_node==NUM_NODES-1) ? 0 : gold_node+1; epoch_tick<=1 for exactly one cycle.
  - stall=1: count, gold_node and outputs all hold; epoch_tick<=0.
- Stamping, latency 1 cycle, when stall=0:
  - out_valid[i] <= in_valid[i].
  - out_flit lane i <= in_flit lane i with bit 0 replaced by: in_valid[i] & (FSM==RUN) & (src[24:20]==gold_node).
  - Any incoming golden bit is overwritten, never OR'd.
  - Invalid lanes: flit bits pass through, bit 0 forced 0.
- Stamping compares against the gold_node register value before any same-edge update. On an epoch_tick edge, flits registered on that edge use the old node; the new node applies from the next edge.
- Source ids >= NUM_NODES are never golden.
- No lane interaction: multiple lanes from the golden node are all stamped. Tie-break between them is done downstream on [19:15].

Optional Feature:
- Macro GOLDEN_EPOCH_STATS_EN.
- Defined:
  - Adds output gold_cnt (16 bits): number of golden flits stamped, i.e. lanes with stamped bit 0 = 1, summed per unstalled cycle (0..4 per cycle).
  - Saturates at 16'hFFFF.
  - Cleared by reset and on every epoch_tick cycle; the count starts again at that cycle's stamps.
- Undefined: no port, no counter logic. All other behaviour identical.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W=32, GOLD_BIT=0, SEQ_MSB=19, SEQ_LSB=15, SRC_MSB=24, SRC_LSB=20.
  - Lane index constants N/E/S/W=0..3.
  - FSM state typedef {IDLE, RUN}.
- One natural sub-module, golden_stamp_lane: the combinational per-lane bit-0 rewrite, instantiated LANES times. The counter and FSM stay in the top level.

Test Plan (EPOCH_LEN=4, NUM_NODES=3 unless noted):
- Reset then en=1, no stall, 12 cycles -> epoch_tick pulses on cycles 4, 8, 12 after entering RUN; gold_node goes 0->1->2->0.
- gold_node=1; lane E valid src=1 with bit0=0; lane W valid src=2 with bit0=1 -> next cycle E bit0=1, W bit0=0, other bits unchanged.
- stall=1 for 3 cycles at count=3 -> no epoch_tick and outputs frozen. Tick fires on the first unstalled cycle; gold_node advances once.
- en=0 at count=2 with gold_node=2 -> IDLE, all stamped bit0=0, gold_node stays 2. Re-enable: first tick after 4 RUN cycles.
- rst_n pulsed low mid-epoch with all 4 lanes valid -> out_valid=0 and gold_node=0 immediately, without waiting for a clock edge.
- GOLDEN_EPOCH_STATS_EN: 4 golden lanes on each of 3 cycles -> gold_cnt=12, reset to 0 on the tick cycle. With NUM_NODES=32, src=31 is stamped when gold_node=31.
